// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU core: register file, flagged ALU and synchronous data
// memory sequenced by a FETCH/EXEC/MEM/WB/HALT state machine.
module multicycle_cpu #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS = 5,
    parameter int REG_BITS = 2,
    localparam int INSTR_WIDTH = 4 + 2 * REG_BITS + DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   result_valid,
    output logic                   zero_flag,
    output logic                   carry_flag,
    output logic                   illegal,
    output logic                   halted,
    input  logic [REG_BITS-1:0]    dbg_sel,
    output logic [DATA_WIDTH-1:0]  dbg_data
);

    typedef enum logic [2:0] {
        FETCH, EXEC, MEM, WB, HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LDI  = 4'd7;
    localparam logic [3:0] OP_LD   = 4'd8;
    localparam logic [3:0] OP_ST   = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    state_t state, state_next;

    logic [INSTR_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0]  regs [2**REG_BITS];
    logic [DATA_WIDTH-1:0]  mem  [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0]  alu_q, mem_q, result_q, wb_val;
    logic [DATA_WIDTH-1:0]  alu_y, a, b;
    logic [DATA_WIDTH:0]    wide;
    logic                   alu_c, alu_cy;

    logic [3:0]            op;
    logic [REG_BITS-1:0]   rd, rs;
    logic [DATA_WIDTH-1:0] imm;
    logic                  is_alu, is_bad;

    assign op  = ir[INSTR_WIDTH-1 -: 4];
    assign rd  = ir[INSTR_WIDTH-5 -: REG_BITS];
    assign rs  = ir[DATA_WIDTH +: REG_BITS];
    assign imm = ir[DATA_WIDTH-1:0];

    assign is_alu = op inside {[4'd1:4'd6], OP_SHL, OP_SHR};
    assign is_bad = op inside {[4'd12:4'd14]};
    assign a = regs[rd];
    assign b = regs[rs];

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: if (instr_valid) state_next = EXEC;
            EXEC: begin
                if (is_alu || op == OP_LDI)        state_next = WB;
                else if (op == OP_LD || op == OP_ST) state_next = MEM;
                else if (op == OP_HALT)             state_next = HALT;
                else                                state_next = FETCH;
            end
            MEM:     state_next = (op == OP_LD) ? WB : FETCH;
            WB:      state_next = FETCH;
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // Reset in flight suppresses the pulses of the aborted instruction.
    always_comb begin
        instr_ready  = (state == FETCH);
        halted       = (state == HALT);
        result_valid = (state == WB) && !rst;
        illegal      = (state == EXEC) && is_bad && !rst;
        result       = result_valid ? wb_val : result_q;
    end

    always_comb begin
        wide   = '0;
        alu_y  = '0;
        alu_cy = 1'b0;
        case (op)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                alu_y  = wide[DATA_WIDTH-1:0];
                alu_cy = wide[DATA_WIDTH];
            end
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                alu_y  = wide[DATA_WIDTH-1:0];
                alu_cy = wide[DATA_WIDTH];
            end
            OP_AND: alu_y = a & b;
            OP_OR:  alu_y = a | b;
            OP_XOR: alu_y = a ^ b;
            OP_ADDI: begin
                wide   = {1'b0, b} + {1'b0, imm};
                alu_y  = wide[DATA_WIDTH-1:0];
                alu_cy = wide[DATA_WIDTH];
            end
            OP_LDI: alu_y = imm;
            OP_SHL: begin
                alu_y  = {b[DATA_WIDTH-2:0], 1'b0};
                alu_cy = b[DATA_WIDTH-1];
            end
            OP_SHR: begin
                alu_y  = {1'b0, b[DATA_WIDTH-1:1]};
                alu_cy = b[0];
            end
            default: ;
        endcase
    end

    assign wb_val = (op == OP_LD) ? mem_q : alu_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ir         <= '0;
            alu_q      <= '0;
            alu_c      <= 1'b0;
            result_q   <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            for (int i = 0; i < 2**REG_BITS; i++) regs[i] <= '0;
        end else begin
            if (state == FETCH && instr_valid) ir <= instruction;
            if (state == EXEC) begin
                alu_q <= alu_y;
                alu_c <= alu_cy;
            end
            if (state == WB) begin
                regs[rd] <= wb_val;
                result_q <= wb_val;
                if (is_alu) begin
                    zero_flag  <= (wb_val == '0);
                    carry_flag <= alu_c;
                end
            end
        end
    end

    // Memory contents survive reset; only the access is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && state == MEM) begin
            if (op == OP_ST) mem[imm[ADDR_BITS-1:0]] <= b;
            mem_q <= mem[imm[ADDR_BITS-1:0]];
        end
    end

    assign dbg_data = regs[dbg_sel];

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu with a queue of expected write-backs.
module tb_multicycle_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instruction = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  result;
    logic        result_valid;
    logic        zero_flag;
    logic        carry_flag;
    logic        illegal;
    logic        halted;
    logic [1:0]  dbg_sel = '0;
    logic [7:0]  dbg_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] val;
        int         lat;
    } exp_t;

    exp_t exp_q[$];

    multicycle_cpu dut (
        .clk(clk),
        .rst(rst),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .result(result),
        .result_valid(result_valid),
        .zero_flag(zero_flag),
        .carry_flag(carry_flag),
        .illegal(illegal),
        .halted(halted),
        .dbg_sel(dbg_sel),
        .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [1:0] rd,
                        input logic [1:0] rs, input logic [7:0] imm,
                        input bit has_res, input logic [7:0] ev,
                        input int lat);
        exp_t e;
        @(negedge clk);
        chk("ready_before_send", instr_ready, 1'b1);
        instruction = {op, rd, rs, imm};
        instr_valid = 1'b1;
        if (has_res) begin
            e.val = ev;
            e.lat = lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instruction = '0;
    endtask

    task automatic wait_wb(input string tag);
        exp_t e;
        int k;
        e = exp_q.pop_front();
        k = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (result_valid) begin
                k = i;
                break;
            end
        end
        chk({tag, "_lat"}, k, e.lat);
        chk({tag, "_val"}, result, e.val);
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] r,
                           input logic [7:0] v);
        dbg_sel = r;
        #1;
        chk(tag, dbg_data, v);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_halted", halted, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_rv", result_valid, 1'b0);
        chk("rst_zero", zero_flag, 1'b0);
        chk("rst_carry", carry_flag, 1'b0);
        for (int i = 0; i < 4; i++) chk_reg("rst_reg", 2'(i), 8'h00);

        send(4'd7, 2'd0, 2'd0, 8'h05, 1, 8'h05, 2);
        wait_wb("ldi_r0");
        send(4'd7, 2'd1, 2'd0, 8'h03, 1, 8'h03, 2);
        wait_wb("ldi_r1");
        send(4'd1, 2'd0, 2'd1, 8'h00, 1, 8'h08, 2);
        wait_wb("add");
        @(negedge clk);
        chk_reg("add_r0", 2'd0, 8'h08);
        chk("add_zero", zero_flag, 1'b0);
        chk("add_carry", carry_flag, 1'b0);
        chk("add_result_hold", result, 8'h08);

        send(4'd7, 2'd2, 2'd0, 8'hFF, 1, 8'hFF, 2);
        wait_wb("ldi_r2");
        send(4'd6, 2'd3, 2'd2, 8'h01, 1, 8'h00, 2);
        wait_wb("addi");
        @(negedge clk);
        chk("addi_zero", zero_flag, 1'b1);
        chk("addi_carry", carry_flag, 1'b1);

        send(4'd7, 2'd0, 2'd0, 8'h02, 1, 8'h02, 2);
        wait_wb("ldi_r0b");
        send(4'd2, 2'd0, 2'd1, 8'h00, 1, 8'hFF, 2);
        wait_wb("sub");
        @(negedge clk);
        chk("sub_zero", zero_flag, 1'b0);
        chk("sub_carry", carry_flag, 1'b1);

        send(4'd9, 2'd0, 2'd1, 8'h1F, 0, 8'h00, 0);
        @(negedge clk);
        chk("st_ready_c1", instr_ready, 1'b0);
        @(negedge clk);
        chk("st_ready_c2", instr_ready, 1'b0);
        send(4'd8, 2'd2, 2'd0, 8'h1F, 1, 8'h03, 3);
        wait_wb("ld");
        @(negedge clk);
        chk_reg("ld_r2", 2'd2, 8'h03);
        chk("ld_zero_kept", zero_flag, 1'b0);
        chk("ld_carry_kept", carry_flag, 1'b1);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ready", instr_ready, 1'b1);
        end

        send(4'd13, 2'd0, 2'd1, 8'h55, 0, 8'h00, 0);
        @(negedge clk);
        chk("illegal_pulse", illegal, 1'b1);
        @(negedge clk);
        chk("illegal_done", illegal, 1'b0);
        chk("illegal_ready", instr_ready, 1'b1);
        chk_reg("ill_r0", 2'd0, 8'hFF);
        chk_reg("ill_r1", 2'd1, 8'h03);
        chk_reg("ill_r2", 2'd2, 8'h03);
        chk_reg("ill_r3", 2'd3, 8'h00);

        send(4'd15, 2'd0, 2'd0, 8'h00, 0, 8'h00, 0);
        instruction = {4'd7, 2'd0, 2'd0, 8'hAA};
        instr_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_halted", halted, 1'b1);
            chk("halt_ready", instr_ready, 1'b0);
        end
        chk_reg("halt_r0", 2'd0, 8'hFF);
        instr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("unhalt", halted, 1'b0);
        for (int i = 0; i < 4; i++) chk_reg("rst2_reg", 2'(i), 8'h00);

        send(4'd7, 2'd0, 2'd0, 8'h07, 1, 8'h07, 2);
        wait_wb("ldi_r0c");
        send(4'd1, 2'd0, 2'd0, 8'h00, 0, 8'h00, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("wb_rst_no_rv", result_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reg("wb_rst_r0", 2'd0, 8'h00);
        chk("wb_rst_ready", instr_ready, 1'b1);
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
